// File: rtl/stopwatch_ctrl.sv
// Stopwatch front panel: 2-FF sync + debounce + press detect per button, then a 4-state mode FSM issuing command pulses.
// Latency: raw edge to pulse = 2 + DEBOUNCE_CYCLES + 1 clk; no backpressure, pulses are fire-and-forget.
// Optional lap counter enabled by defining STOPWATCH_CTRL_LAP_EN.
`timescale 1ns/1ps
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DB_W            = 20
`ifdef STOPWATCH_CTRL_LAP_EN
  ,
  parameter int LAP_W           = 4
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_ss,
  input  logic             btn_sr,
  output logic             start,
  output logic             stop,
  output logic             split,
  output logic             zero,
  output logic [1:0]       mode
`ifdef STOPWATCH_CTRL_LAP_EN
  ,
  output logic [LAP_W-1:0] lap_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    SPLIT = 2'b10,
    HALT  = 2'b11
  } state_t;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Bit 0 is start/stop, bit 1 is split/reset.
  logic [1:0]      btn_raw;
  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0]      db;
  logic [1:0]      db_prev;
  logic [DB_W-1:0] cnt [2];
  logic [1:0]      press;
  logic            ss_ev;
  logic            sr_ev;
  state_t          state;

  assign btn_raw = {btn_sr, btn_ss};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      db      <= '0;
      db_prev <= '0;
      cnt[0]  <= '0;
      cnt[1]  <= '0;
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      db_prev <= db;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          db[i]  <= ~db[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Only the rising edge of the filtered level counts; release is silent.
  assign press = db & ~db_prev;
  assign ss_ev = press[0];
  assign sr_ev = press[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      start     <= 1'b0;
      stop      <= 1'b0;
      split     <= 1'b0;
      zero      <= 1'b0;
`ifdef STOPWATCH_CTRL_LAP_EN
      lap_count <= '0;
`endif
    end else begin
      start <= 1'b0;
      stop  <= 1'b0;
      split <= 1'b0;
      zero  <= 1'b0;
      // start/stop takes priority; a coincident split/reset press is dropped.
      case (state)
        IDLE: begin
          if (ss_ev) begin
            start <= 1'b1;
            state <= RUN;
          end else if (sr_ev) begin
            zero  <= 1'b1;
`ifdef STOPWATCH_CTRL_LAP_EN
            lap_count <= '0;
`endif
          end
        end
        RUN: begin
          if (ss_ev) begin
            stop  <= 1'b1;
            state <= HALT;
          end else if (sr_ev) begin
            split <= 1'b1;
            state <= SPLIT;
`ifdef STOPWATCH_CTRL_LAP_EN
            if (lap_count != {LAP_W{1'b1}}) lap_count <= lap_count + 1'b1;
`endif
          end
        end
        SPLIT: begin
          if (ss_ev) begin
            stop  <= 1'b1;
            split <= 1'b1;
            state <= HALT;
          end else if (sr_ev) begin
            split <= 1'b1;
            state <= RUN;
          end
        end
        HALT: begin
          if (ss_ev) begin
            start <= 1'b1;
            state <= RUN;
          end else if (sr_ev) begin
            zero  <= 1'b1;
            state <= IDLE;
`ifdef STOPWATCH_CTRL_LAP_EN
            lap_count <= '0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mode = state;

endmodule
